// File: rtl/jp4diff_pkg.sv
// rtl/jp4diff_pkg.sv - shared constants, address swizzle and saturation for JP4-diff reconstruction
package jp4diff_pkg;
  localparam int TILE_PIXELS = 256;
  localparam int BASE_OFFSET = 128;
  localparam int SUM_BITS    = 11;

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  // scanline index {row,col} -> block-order address {row[0],row[3:1],col[0],col[3:1]}
  function automatic logic [7:0] swizzle(input logic [7:0] idx);
    return {idx[4], idx[7:5], idx[0], idx[3:1]};
  endfunction

  function automatic logic [7:0] sat8(input logic [SUM_BITS-1:0] v);
    if (v[SUM_BITS-1])
      return 8'd0;
    else if (|v[SUM_BITS-2:8])
      return 8'hff;
    else
      return v[7:0];
  endfunction
endpackage

// File: rtl/jp4diff_tile_buf.sv
// rtl/jp4diff_tile_buf.sv - ping-pong 2x256 sample memory with full flags and page pointers
module jp4diff_tile_buf #(
  parameter int DIN_BITS = 9
) (
  input  logic                clk,
  input  logic                flush,
  input  logic                we,
  input  logic [7:0]          waddr,
  input  logic [DIN_BITS-1:0] wdata,
  input  logic                done,
  input  logic                rel,
  input  logic [7:0]          raddr_own,
  input  logic [7:0]          raddr_base,
  output logic [DIN_BITS-1:0] rdata_own,
  output logic [DIN_BITS-1:0] rdata_base,
  output logic                page_rdy,
  output logic                commit,
  output logic                overrun,
  output logic                wpage,
  output logic                rpage,
  output logic                rd_full,
  output logic                next_full
);
  logic [DIN_BITS-1:0] mem [512];
  logic [1:0]          full;
  logic [1:0]          full_nxt;

  assign page_rdy  = ~full[wpage];
  assign commit    = done & ~flush & ~full[wpage];
  assign rd_full   = full[rpage];
  assign next_full = full[~rpage];

  // commit and release always target different pages, so both can land together
  always_comb begin
    full_nxt = full;
    if (rel)
      full_nxt[rpage] = 1'b0;
    if (commit)
      full_nxt[wpage] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      full    <= 2'b00;
      wpage   <= 1'b0;
      rpage   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      full    <= full_nxt;
      overrun <= done & full[wpage];
      if (commit)
        wpage <= ~wpage;
      if (rel)
        rpage <= ~rpage;
    end
  end

  always_ff @(posedge clk) begin
    if (we & ~flush)
      mem[{wpage, waddr}] <= wdata;
    rdata_own  <= mem[{rpage, raddr_own}];
    rdata_base <= mem[{rpage, raddr_base}];
  end
endmodule

// File: rtl/jp4diff_reconstruct.sv
// rtl/jp4diff_reconstruct.sv - JP4-differential inverse: block-order tile in, scanline Bayer pixels out
// Optional: define JP4DIFF_RECON_HDR_EN to honour the hdr (absolute diagonal pixel) setting.
module jp4diff_reconstruct #(
  parameter int DIN_BITS  = 9,
  parameter int DOUT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIN_BITS-1:0]  din,
  input  logic                 din_we,
  input  logic [7:0]           din_addr,
  input  logic                 din_done,
  input  logic                 scale_diff,
  input  logic                 hdr,
  input  logic [1:0]           bayer_phase,
  output logic                 din_page_rdy,
  output logic                 overrun,
  output logic [DOUT_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 pre_first_out
);
  import jp4diff_pkg::*;

  logic                flush;
  rd_state_t           state, state_nxt;
  logic [7:0]          idx, idx_nxt;
  logic                run, rel;
  logic                page_rdy, commit, wpage, rpage, rd_full, next_full;
  logic [DIN_BITS-1:0] rdata_own, rdata_base;
  logic [7:0]          raddr_base;
  logic [1:0]          cfg_scale, cfg_hdr;
  logic [1:0][1:0]     cfg_phase;

  assign flush        = rst | ~en;
  assign din_page_rdy = en & page_rdy;
  assign raddr_base   = {cfg_phase[rpage][1], idx[7:5], cfg_phase[rpage][0], idx[3:1]};

  jp4diff_tile_buf #(.DIN_BITS(DIN_BITS)) u_buf (
    .clk       (clk),
    .flush     (flush),
    .we        (din_we),
    .waddr     (din_addr),
    .wdata     (din),
    .done      (din_done),
    .rel       (rel),
    .raddr_own (swizzle(idx)),
    .raddr_base(raddr_base),
    .rdata_own (rdata_own),
    .rdata_base(rdata_base),
    .page_rdy  (page_rdy),
    .commit    (commit),
    .overrun   (overrun),
    .wpage     (wpage),
    .rpage     (rpage),
    .rd_full   (rd_full),
    .next_full (next_full)
  );

  always_ff @(posedge clk) begin
    if (commit) begin
      cfg_scale[wpage] <= scale_diff;
      cfg_phase[wpage] <= bayer_phase;
`ifdef JP4DIFF_RECON_HDR_EN
      cfg_hdr[wpage]   <= hdr;
`else
      cfg_hdr[wpage]   <= hdr & 1'b0;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    run       = 1'b0;
    rel       = 1'b0;
    case (state)
      RD_IDLE: begin
        if (rd_full) begin
          state_nxt = RD_RUN;
          idx_nxt   = 8'd0;
        end
      end
      RD_RUN: begin
        run = 1'b1;
        if (idx == 8'(TILE_PIXELS - 1)) begin
          rel     = 1'b1;
          idx_nxt = 8'd0;
          if (!next_full)
            state_nxt = RD_IDLE;
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= RD_IDLE;
      idx   <= 8'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // per-pixel settings travel alongside the read data
  logic                v1, first1, hdr1, scale1, v2;
  logic [1:0]          pos1, phase1;
  logic [SUM_BITS-1:0] sum2;

  logic                abs_pix;
  logic [SUM_BITS-1:0] own_x, base_x, base_abs, diff, sum_c;

  always_comb begin
    own_x    = {{(SUM_BITS-DIN_BITS){rdata_own[DIN_BITS-1]}}, rdata_own};
    base_x   = {{(SUM_BITS-DIN_BITS){rdata_base[DIN_BITS-1]}}, rdata_base};
    base_abs = {3'b000, sat8(base_x + SUM_BITS'(BASE_OFFSET))};
    diff     = scale1 ? {own_x[SUM_BITS-2:0], 1'b0} : own_x;
    abs_pix  = (pos1 == phase1) || (hdr1 && (pos1 == (phase1 ^ 2'b11)));
    sum_c    = abs_pix ? own_x + SUM_BITS'(BASE_OFFSET) : base_abs + diff;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      v1            <= 1'b0;
      first1        <= 1'b0;
      pos1          <= 2'b00;
      phase1        <= 2'b00;
      hdr1          <= 1'b0;
      scale1        <= 1'b0;
      v2            <= 1'b0;
      sum2          <= '0;
      pre_first_out <= 1'b0;
      dout_valid    <= 1'b0;
      dout          <= '0;
    end else begin
      v1            <= run;
      first1        <= run && (idx == 8'd0);
      pos1          <= {idx[4], idx[0]};
      phase1        <= cfg_phase[rpage];
      hdr1          <= cfg_hdr[rpage];
      scale1        <= cfg_scale[rpage];
      v2            <= v1;
      sum2          <= sum_c;
      pre_first_out <= v1 & first1;
      dout_valid    <= v2;
      dout          <= DOUT_BITS'(sat8(sum2));
    end
  end
endmodule

// File: tb/tb_jp4diff_reconstruct.sv
// tb/tb_jp4diff_reconstruct.sv - directed self-checking bench for jp4diff_reconstruct
module tb_jp4diff_reconstruct;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [8:0] din = '0;
  logic       din_we = 1'b0;
  logic [7:0] din_addr = '0;
  logic       din_done = 1'b0;
  logic       scale_diff = 1'b0;
  logic       hdr = 1'b0;
  logic [1:0] bayer_phase = 2'b00;
  logic       din_page_rdy, overrun, dout_valid, pre_first_out;
  logic [7:0] dout;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_pre = 1'b0;

  always #5 clk = ~clk;

  jp4diff_reconstruct dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_we(din_we), .din_addr(din_addr),
    .din_done(din_done), .scale_diff(scale_diff), .hdr(hdr), .bayer_phase(bayer_phase),
    .din_page_rdy(din_page_rdy), .overrun(overrun), .dout(dout), .dout_valid(dout_valid),
    .pre_first_out(pre_first_out)
  );

`ifdef JP4DIFF_RECON_HDR_EN
  localparam logic [7:0] HDR_PIX = 8'd148;
`else
  localparam logic [7:0] HDR_PIX = 8'd178;
`endif

  // samples indexed by {row[0],col[0]}; settings scrambled after commit
  task automatic write_tile(input logic [8:0] s0, s1, s2, s3,
                            input logic sc, input logic hd, input logic [1:0] ph);
    logic [8:0] s [4];
    logic [7:0] a;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < 256; k++) begin
      a        = 8'(k);
      din_we   = 1'b1;
      din_addr = a;
      din      = s[{a[7], a[3]}];
      @(negedge clk);
    end
    din_we      = 1'b0;
    din_done    = 1'b1;
    scale_diff  = sc;
    hdr         = hd;
    bayer_phase = ph;
    @(negedge clk);
    din_done    = 1'b0;
    scale_diff  = ~sc;
    hdr         = ~hd;
    bayer_phase = ~ph;
  endtask

  task automatic collect(input logic [7:0] e0, e1, e2, e3, input bit cont,
                         input int n, input string tag);
    logic [7:0] ev [4];
    logic [7:0] exp_px;
    int t;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    if (cont) begin
      @(negedge clk);
    end else begin
      t = 0;
      while (dout_valid !== 1'b1 && t < 3000) begin
        last_pre = pre_first_out;
        @(negedge clk);
        t++;
      end
      n_cmp++;
      if (dout_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_start: dout_valid=%b after %0d cycles, want 1", tag, dout_valid, t);
        return;
      end
    end
    n_cmp++;
    if (last_pre !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_pre_first: pre_first_out before pixel 0 = %b, want 1", tag, last_pre);
    end
    for (int i = 0; i < n; i++) begin
      exp_px = ev[{i[4], i[0]}];
      n_cmp++;
      if ({dout_valid, dout} !== {1'b1, exp_px}) begin
        n_bad++;
        $display("FAIL %s_pix%0d: valid=%b dout=%0d, want valid=1 dout=%0d",
                 tag, i, dout_valid, dout, exp_px);
      end
      last_pre = pre_first_out;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({din_page_rdy, overrun, dout_valid, pre_first_out, dout} !== {4'b1000, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_outs: rdy/ovr/val/pre=%b%b%b%b dout=%0d, want 1000 dout=0",
               din_page_rdy, overrun, dout_valid, pre_first_out, dout);
    end
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (din_page_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL en_low_rdy: din_page_rdy=%b, want 0", din_page_rdy);
    end
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    write_tile(9'd0, 9'd5, 9'd5, 9'd5, 1'b0, 1'b0, 2'b00);
    collect(8'd128, 8'd133, 8'd133, 8'd133, 1'b0, 256, "basic");
  endtask

  task automatic test_scale;
    write_tile(9'd0, 9'h1FD, 9'h1FD, 9'h1FD, 1'b1, 1'b0, 2'b00);
    collect(8'd128, 8'd122, 8'd122, 8'd122, 1'b0, 256, "scale");
  endtask

  task automatic test_saturate;
    write_tile(9'd127, 9'd10, 9'd10, 9'd10, 1'b0, 1'b0, 2'b00);
    collect(8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 256, "sat_hi");
    write_tile(9'h180, 9'h1FF, 9'h1FF, 9'h1FF, 1'b0, 1'b0, 2'b00);
    collect(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 256, "sat_lo");
    write_tile(9'h1F6, 9'h1F6, 9'h1F6, 9'd127, 1'b0, 1'b0, 2'b11);
    collect(8'd245, 8'd245, 8'd245, 8'd255, 1'b0, 256, "phase11");
  endtask

  task automatic test_hdr;
    write_tile(9'd5, 9'd30, 9'd20, 9'd5, 1'b0, 1'b1, 2'b01);
    collect(8'd163, 8'd158, HDR_PIX, 8'd163, 1'b0, 256, "hdr");
  endtask

  // page 1 still holds the hdr tile's samples; it is recommitted here with new settings
  task automatic test_back_to_back;
    int nv;
    write_tile(9'd0, 9'd5, 9'd5, 9'd5, 1'b0, 1'b0, 2'b00);
    din_done = 1'b1; hdr = 1'b1; bayer_phase = 2'b01; scale_diff = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (din_page_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_full_rdy: din_page_rdy=%b, want 0", din_page_rdy);
    end
    hdr = 1'b0; bayer_phase = 2'b10; scale_diff = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_overrun: overrun=%b, want 1", overrun);
    end
    din_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({overrun, din_page_rdy} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_overrun_pulse: overrun=%b rdy=%b, want 0 0", overrun, din_page_rdy);
    end
    collect(8'd128, 8'd133, 8'd133, 8'd133, 1'b0, 256, "b2b_a");
    n_cmp++;
    if (din_page_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_drain_rdy: din_page_rdy=%b, want 1", din_page_rdy);
    end
    collect(8'd163, 8'd158, HDR_PIX, 8'd163, 1'b1, 256, "b2b_b");
    nv = 0;
    repeat (300) begin
      @(negedge clk);
      if (dout_valid === 1'b1) nv++;
    end
    n_cmp++;
    if (nv !== 0) begin
      n_bad++;
      $display("FAIL b2b_dropped: %0d extra valids, want 0", nv);
    end
  endtask

  task automatic test_mid_reset;
    int nv;
    write_tile(9'd7, 9'd7, 9'h1CE, 9'd7, 1'b1, 1'b0, 2'b10);
    collect(8'd92, 8'd92, 8'd78, 8'd92, 1'b0, 101, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dout_valid, din_page_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_rst: dout_valid=%b din_page_rdy=%b, want 0 1", dout_valid, din_page_rdy);
    end
    rst = 1'b0;
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (dout_valid === 1'b1) nv++;
    end
    n_cmp++;
    if (nv !== 0) begin
      n_bad++;
      $display("FAIL mid_rst_tail: %0d valids after reset, want 0", nv);
    end
    write_tile(9'h1EC, 9'h1EC, 9'h1EC, 9'd100, 1'b0, 1'b0, 2'b11);
    collect(8'd208, 8'd208, 8'd208, 8'd228, 1'b0, 256, "post_rst");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_scale;
    test_saturate;
    test_hdr;
    test_back_to_back;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jp4diff_reconstruct.md
Name: jp4diff_reconstruct

Overview:
Inverse of the JP4-differential colour conversion, used on the decode/verification path. Accepts one 16x16 tile as four 8x8 blocks of signed 9-bit samples in block order. Restores the absolute 8-bit Bayer pixels and streams them out in scanline order. A ping-pong tile buffer lets the writer fill one page while the reader drains the other.

Parameters:
DIN_BITS, 9, width of signed input samples (two's complement)
DOUT_BITS, 8, width of reconstructed unsigned pixels

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  block enable; low = flush (same effect as rst)
din  input  DIN_BITS  block-order sample (Y = abs−128, colour = diff, optionally halved)
din_we  input  1  write strobe for din
din_addr  input  8  block-order address {row[0],row[3:1],col[0],col[3:1]}
din_done  input  1  pulse: current write page complete, commit tile
scale_diff  input  1  diffs were halved; sampled at din_done
hdr  input  1  diagonal-to-base pixel is absolute; sampled at din_done
bayer_phase  input  2  {row[0],col[0]} of base pixel; sampled at din_done
din_page_rdy  output  1  a write page is free
overrun  output  1  one-cycle pulse: din_done while no page free
dout  output  DOUT_BITS  reconstructed pixel, scanline order
dout_valid  output  1  dout valid
pre_first_out  output  1  high the cycle before dout_valid of pixel 0 of each tile

Behaviour:
- Reset/en low: both pages empty, reader IDLE; din_page_rdy=1 (0 while en low); dout=0, dout_valid=0, pre_first_out=0, overrun=0. Mid-tile reset drops both pages; no partial output after the reset cycle.
- Write side: din_we writes din to wpage[din_addr]. din_done with a free page: tile settings are latched per page and the page is marked full. The write page toggles.
- din_done with both pages full (din_page_rdy=0): tile is discarded and overrun pulses.
- din_done and reader release in the same cycle are both honoured; the full count stays unchanged.
- Reader FSM: IDLE -> RUN when a page is full. RUN steps scanline index i=0..255 (row=i[7:4], col=i[3:0]) one per cycle.
- At i=255: if the other page is full, go straight to RUN on it with no gap. Otherwise release the page and return to IDLE.
- Per pixel, two reads of the same page:
  - own sample at {row[0],row[3:1],col[0],col[3:1]};
  - base sample at {bayer_phase[1],row[3:1],bayer_phase[0],col[3:1]}.
- Pipeline: address cycle 0 -> read-data register cycle 1 -> add cycle 2 -> saturate/output register cycle 3. dout_valid is the run flag delayed 3 cycles. pre_first_out marks the cycle before index 0 reaches the output.
- Arithmetic, with pos={row[0],col[0]}:
  - pos==bayer_phase: dout = sat(y+128).
  - hdr latched and pos==bayer_phase^2'b11: dout = sat(y+128).
  - otherwise: dout = sat(sat(base+128) + (scale_diff ? d<<1 : d)).
  - Sums are formed in 11-bit signed; sat clamps to 0..255.
- Settings used for a tile are those latched at its din_done. Live input changes never affect a committed tile.

Optional Feature:
JP4DIFF_RECON_HDR_EN
- Defined: hdr is latched and honoured as above.
- Undefined: hdr is ignored, latched value is forced to 0, and all non-base pixels are treated as differences; the port remains.

Decomposition:
- Shared package (jp4diff_pkg): constants TILE_PIXELS=256, BASE_OFFSET=128; the address-swizzle function (scanline index -> block address); the 11-bit-to-8-bit saturate function.
- One sub-module, jp4diff_tile_buf:
  - 2x256xDIN_BITS ping-pong memory;
  - one write port and two registered read ports on the selected page;
  - full flags plus page toggling.

Test Plan:
- Phase 00, no scale/hdr: base samples 0x000, all diffs +5 -> pixels 128 at (even,even), 133 elsewhere, 256 valids, pre_first_out one cycle before the first.
- scale_diff=1, base 0x000, diffs −3 -> 122 on non-base pixels; base 128.
- Saturation: base +127, diff +10 -> 255; base −128, diff −1 -> 0.
- hdr=1, phase 01, sample at pos 10 = +20 -> 148 independent of base; with macro undefined -> base+20.
- Two din_done back to back -> 512 contiguous valids, pre_first_out before pixels 0 and 256, din_page_rdy low until first tile drains; third din_done while full -> overrun pulse, tile dropped.
- rst asserted at pixel 100 of a tile -> dout_valid=0 next cycle, din_page_rdy=1, next tile reconstructs correctly.
